// File: rtl/otter_intr_ctrl.sv
// Fixed-priority interrupt scheduler for the OTTER multicycle CU: edge-latched pending bits,
// enable mask, single INTR line held until INT_TAKEN, blocked until MRET. Option: OTTER_INTR_SYNC_EN.
module otter_intr_ctrl #(
  parameter int NSRC = 4,
  localparam int CW = $clog2(NSRC)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NSRC-1:0] IRQ,
  input  logic            MIE,
  input  logic            MASK_WE,
  input  logic [NSRC-1:0] MASK_WD,
  input  logic            INT_TAKEN,
  input  logic            MRET,
  output logic            INTR,
  output logic [CW-1:0]   CAUSE,
  output logic            IN_SVC,
  output logic [NSRC-1:0] PEND
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_SVC  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [NSRC-1:0] irq_q, irq_s, rise, elig, clr;
  logic [CW-1:0]   cause_q, cause_d, winner;

`ifdef OTTER_INTR_SYNC_EN
  logic [NSRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= IRQ;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = IRQ;
`endif

  assign rise = irq_s & ~irq_q;
  assign elig = pend_q & mask_q;

  // Scan downward so the lowest eligible index is the last (winning) assignment.
  always_comb begin
    winner = '0;
    for (int unsigned i = NSRC; i > 0; i--) begin
      if (elig[i-1]) winner = CW'(i - 1);
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    clr     = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (MIE && (elig != '0)) begin
          state_d = ST_REQ;
          cause_d = winner;
        end
      end
      ST_REQ: begin
        if (INT_TAKEN) begin
          state_d      = ST_SVC;
          clr[cause_q] = 1'b1;
        end else if (!MIE || !mask_q[cause_q]) begin
          state_d = ST_IDLE;
        end
      end
      ST_SVC: begin
        if (MRET) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A new edge on the bit being taken must survive the clear.
  assign pend_d = (pend_q & ~clr) | rise;
  assign mask_d = MASK_WE ? MASK_WD : mask_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      mask_q  <= '0;
      irq_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      irq_q   <= irq_s;
      cause_q <= cause_d;
    end
  end

  assign INTR   = (state_q == ST_REQ);
  assign IN_SVC = (state_q == ST_SVC);
  assign CAUSE  = cause_q;
  assign PEND   = pend_q;

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// Directed, table-driven bench for otter_intr_ctrl (default build, NSRC=4, no IRQ synchroniser).
module tb_otter_intr_ctrl;

  logic       CLK = 1'b0;
  logic       RST, MIE, MASK_WE, INT_TAKEN, MRET;
  logic [3:0] IRQ, MASK_WD;
  logic       INTR, IN_SVC;
  logic [1:0] CAUSE;
  logic [3:0] PEND;

  int errors = 0;
  int checks = 0;

  otter_intr_ctrl #(.NSRC(4)) dut (
    .CLK(CLK), .RST(RST), .IRQ(IRQ), .MIE(MIE),
    .MASK_WE(MASK_WE), .MASK_WD(MASK_WD),
    .INT_TAKEN(INT_TAKEN), .MRET(MRET),
    .INTR(INTR), .CAUSE(CAUSE), .IN_SVC(IN_SVC), .PEND(PEND)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit       rst;
    bit [3:0] irq;
    bit       mie;
    bit       we;
    bit [3:0] wd;
    bit       tk;
    bit       mr;
    bit       e_intr;
    bit [1:0] e_cause;
    bit       e_svc;
    bit [3:0] e_pend;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, bit [3:0] irq, bit mie, bit we, bit [3:0] wd,
                              bit tk, bit mr, bit e_intr, bit [1:0] e_cause,
                              bit e_svc, bit [3:0] e_pend);
    vec_t v;
    v.rst = rst; v.irq = irq; v.mie = mie; v.we = we; v.wd = wd; v.tk = tk; v.mr = mr;
    v.e_intr = e_intr; v.e_cause = e_cause; v.e_svc = e_svc; v.e_pend = e_pend;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    RST = v.rst; IRQ = v.irq; MIE = v.mie; MASK_WE = v.we; MASK_WD = v.wd;
    INT_TAKEN = v.tk; MRET = v.mr;
  endtask

  task automatic idle_inputs();
    RST = 1'b0; IRQ = '0; MASK_WE = 1'b0; MASK_WD = '0; INT_TAKEN = 1'b0; MRET = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int lat;
    bit seen;
    RST = 1'b1; IRQ = '0; MIE = 1'b0; MASK_WE = 1'b0; MASK_WD = '0; INT_TAKEN = 1'b0; MRET = 1'b0;

    //                  rst irq   mie we wd    tk mr | intr cause svc pend
    vecs.push_back(mk(1, 4'h0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 4'h0)); // 0 reset
    vecs.push_back(mk(1, 4'h0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 4'h0)); // 1
    vecs.push_back(mk(0, 4'h0, 1, 1, 4'hF, 0, 0, 0, 0, 0, 4'h0)); // 2 mask=1111
    vecs.push_back(mk(0, 4'h4, 1, 0, 4'h0, 0, 0, 0, 0, 0, 4'h4)); // 3 IRQ[2] rise
    vecs.push_back(mk(0, 4'h0, 1, 0, 4'h0, 0, 0, 1, 2, 0, 4'h4)); // 4 request cause 2
    vecs.push_back(mk(0, 4'h0, 1, 0, 4'h0, 1, 0, 0, 2, 1, 4'h0)); // 5 taken
    vecs.push_back(mk(0, 4'hA, 1, 0, 4'h0, 0, 0, 0, 2, 1, 4'hA)); // 6 IRQ[3],IRQ[1] in svc
    vecs.push_back(mk(0, 4'h0, 1, 0, 4'h0, 0, 1, 0, 2, 0, 4'hA)); // 7 mret
    vecs.push_back(mk(0, 4'h0, 1, 0, 4'h0, 0, 0, 1, 1, 0, 4'hA)); // 8 cause 1 wins
    vecs.push_back(mk(0, 4'h0, 1, 0, 4'h0, 1, 0, 0, 1, 1, 4'h8)); // 9
    vecs.push_back(mk(0, 4'h0, 1, 0, 4'h0, 0, 1, 0, 1, 0, 4'h8)); // 10
    vecs.push_back(mk(0, 4'h0, 1, 0, 4'h0, 0, 0, 1, 3, 0, 4'h8)); // 11 cause 3 after return
    vecs.push_back(mk(0, 4'h0, 1, 0, 4'h0, 1, 0, 0, 3, 1, 4'h0)); // 12
    vecs.push_back(mk(0, 4'h0, 1, 0, 4'h0, 0, 1, 0, 3, 0, 4'h0)); // 13
    vecs.push_back(mk(0, 4'h0, 1, 1, 4'h1, 0, 0, 0, 3, 0, 4'h0)); // 14 mask=0001
    vecs.push_back(mk(0, 4'h4, 1, 0, 4'h0, 0, 0, 0, 3, 0, 4'h4)); // 15 masked IRQ[2]
    vecs.push_back(mk(0, 4'h0, 1, 0, 4'h0, 0, 0, 0, 3, 0, 4'h4)); // 16
    vecs.push_back(mk(0, 4'h0, 1, 0, 4'h0, 0, 0, 0, 3, 0, 4'h4)); // 17
    vecs.push_back(mk(0, 4'h0, 1, 1, 4'h4, 0, 0, 0, 3, 0, 4'h4)); // 18 mask=0100 (next cycle)
    vecs.push_back(mk(0, 4'h0, 1, 0, 4'h0, 0, 0, 1, 2, 0, 4'h4)); // 19
    vecs.push_back(mk(0, 4'h0, 1, 1, 4'h0, 0, 0, 1, 2, 0, 4'h4)); // 20 mask=0, old mask still used
    vecs.push_back(mk(0, 4'h0, 1, 0, 4'h0, 0, 0, 0, 2, 0, 4'h4)); // 21 withdrawn, pend kept
    vecs.push_back(mk(0, 4'h0, 1, 1, 4'hF, 0, 0, 0, 2, 0, 4'h4)); // 22
    vecs.push_back(mk(0, 4'h1, 1, 0, 4'h0, 0, 0, 1, 2, 0, 4'h5)); // 23
    vecs.push_back(mk(0, 4'h0, 1, 0, 4'h0, 1, 0, 0, 2, 1, 4'h1)); // 24
    vecs.push_back(mk(0, 4'h0, 1, 0, 4'h0, 0, 1, 0, 2, 0, 4'h1)); // 25
    vecs.push_back(mk(0, 4'h0, 1, 0, 4'h0, 0, 0, 1, 0, 0, 4'h1)); // 26 cause 0
    vecs.push_back(mk(0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 4'h1)); // 27 MIE drop
    vecs.push_back(mk(0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 4'h1)); // 28
    vecs.push_back(mk(0, 4'h0, 1, 0, 4'h0, 0, 0, 1, 0, 0, 4'h1)); // 29 MIE back
    vecs.push_back(mk(0, 4'h0, 0, 0, 4'h0, 1, 0, 0, 0, 1, 4'h0)); // 30 take beats withdraw
    vecs.push_back(mk(0, 4'h1, 1, 0, 4'h0, 1, 0, 0, 0, 1, 4'h1)); // 31 stray take, IRQ[0] in svc
    vecs.push_back(mk(0, 4'h0, 1, 0, 4'h0, 0, 0, 0, 0, 1, 4'h1)); // 32
    vecs.push_back(mk(0, 4'h0, 1, 0, 4'h0, 0, 1, 0, 0, 0, 4'h1)); // 33
    vecs.push_back(mk(0, 4'h0, 1, 0, 4'h0, 0, 0, 1, 0, 0, 4'h1)); // 34
    vecs.push_back(mk(0, 4'h0, 1, 0, 4'h0, 1, 0, 0, 0, 1, 4'h0)); // 35
    vecs.push_back(mk(0, 4'h2, 1, 0, 4'h0, 0, 0, 0, 0, 1, 4'h2)); // 36
    vecs.push_back(mk(0, 4'h0, 1, 0, 4'h0, 0, 1, 0, 0, 0, 4'h2)); // 37
    vecs.push_back(mk(0, 4'h0, 1, 0, 4'h0, 0, 0, 1, 1, 0, 4'h2)); // 38
    vecs.push_back(mk(0, 4'h2, 1, 0, 4'h0, 1, 0, 0, 1, 1, 4'h2)); // 39 set wins over clear
    vecs.push_back(mk(0, 4'h2, 1, 0, 4'h0, 0, 0, 0, 1, 1, 4'h2)); // 40 level, no new edge
    vecs.push_back(mk(0, 4'h0, 1, 0, 4'h0, 0, 1, 0, 1, 0, 4'h2)); // 41
    vecs.push_back(mk(0, 4'h0, 1, 0, 4'h0, 0, 0, 1, 1, 0, 4'h2)); // 42
    vecs.push_back(mk(0, 4'h0, 1, 0, 4'h0, 0, 1, 1, 1, 0, 4'h2)); // 43 mret in REQ ignored
    vecs.push_back(mk(0, 4'h0, 1, 0, 4'h0, 1, 0, 0, 1, 1, 4'h0)); // 44
    vecs.push_back(mk(0, 4'h4, 1, 0, 4'h0, 0, 0, 0, 1, 1, 4'h4)); // 45
    vecs.push_back(mk(1, 4'h4, 1, 0, 4'h0, 0, 0, 0, 0, 0, 4'h0)); // 46 reset in svc
    vecs.push_back(mk(0, 4'h4, 1, 0, 4'h0, 0, 0, 0, 0, 0, 4'h4)); // 47 high at release = edge
    vecs.push_back(mk(0, 4'h4, 1, 0, 4'h0, 0, 0, 0, 0, 0, 4'h4)); // 48 mask cleared by reset
    vecs.push_back(mk(0, 4'h4, 1, 1, 4'hF, 0, 0, 0, 0, 0, 4'h4)); // 49
    vecs.push_back(mk(0, 4'h4, 1, 0, 4'h0, 0, 0, 1, 2, 0, 4'h4)); // 50

    #2;
    foreach (vecs[i]) begin
      drive(vecs[i]);
      tick();
      chk($sformatf("v%0d.INTR", i),   INTR,   vecs[i].e_intr);
      chk($sformatf("v%0d.CAUSE", i),  CAUSE,  vecs[i].e_cause);
      chk($sformatf("v%0d.IN_SVC", i), IN_SVC, vecs[i].e_svc);
      chk($sformatf("v%0d.PEND", i),   PEND,   vecs[i].e_pend);
    end

    // INTR must not react combinationally to INT_TAKEN; only after the edge.
    idle_inputs();
    IRQ = 4'h4;
    INT_TAKEN = 1'b1;
    #2;
    chk("nocomb.INTR", INTR, 1);
    tick();
    chk("take.INTR", INTR, 0);
    chk("take.IN_SVC", IN_SVC, 1);
    idle_inputs();
    MRET = 1'b1;
    tick();
    chk("mret.IN_SVC", IN_SVC, 0);
    idle_inputs();

    // Fresh reset, then measure IRQ-to-INTR latency with a bounded wait.
    RST = 1'b1;
    tick();
    RST = 1'b0; MASK_WE = 1'b1; MASK_WD = 4'hF; MIE = 1'b1;
    tick();
    idle_inputs();
    IRQ = 4'h8;
    tick();
    IRQ = 4'h0;
    lat = 1;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      tick();
      lat++;
      if (INTR) seen = 1'b1;
    end
    chk("lat.seen", seen, 1);
    chk("lat.cycles", lat, 2);
    chk("lat.CAUSE", CAUSE, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
